// File: rtl/flags_decoder.sv
// Binary-to-one-hot decoder for the control unit's ALU flag vector.
// Provides a same-cycle decode plus a registered copy with a valid flag.
module flags_decoder #(
  parameter int unsigned IN_W  = 2,
  parameter int unsigned OUT_W = 2 ** IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [IN_W-1:0]  sel,
  output logic [OUT_W-1:0] dec,
  output logic             in_range,
  output logic [OUT_W-1:0] dec_q,
  output logic             valid_q
);

  // One extra bit so OUT_W == 2**IN_W is representable in the range compare
  localparam int unsigned CMP_W = IN_W + 1;

  if (IN_W < 1 || OUT_W < 1 || OUT_W > 2 ** IN_W) begin : g_bad_param
    $fatal(1, "flags_decoder: OUT_W=%0d illegal for IN_W=%0d", OUT_W, IN_W);
  end

  // Equality compares keep X on sel visible instead of resolving to a bit
  always_comb begin
    dec = '0;
    for (int unsigned k = 0; k < OUT_W; k++) begin
      dec[k] = en & (sel == IN_W'(k));
    end
  end

  assign in_range = ({1'b0, sel} < CMP_W'(OUT_W));

  // en=0 already zeroes dec, so the register never holds a stale code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      dec_q   <= dec;
      valid_q <= en & in_range;
    end
  end

endmodule

// File: tb/tb_flags_decoder.sv
// Directed and random checks of flags_decoder with OUT_W=4 and OUT_W=3.
module tb_flags_decoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] sel;

  logic [3:0] dec_a, dec_q_a;
  logic       in_range_a, valid_q_a;
  logic [2:0] dec_b, dec_q_b;
  logic       in_range_b, valid_q_b;

  int checks;
  int failures;

  flags_decoder #(.IN_W(2), .OUT_W(4)) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sel      (sel),
    .dec      (dec_a),
    .in_range (in_range_a),
    .dec_q    (dec_q_a),
    .valid_q  (valid_q_a)
  );

  flags_decoder #(.IN_W(2), .OUT_W(3)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sel      (sel),
    .dec      (dec_b),
    .in_range (in_range_b),
    .dec_q    (dec_q_b),
    .valid_q  (valid_q_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode for an n-output decoder
  function automatic logic [3:0] ref_dec(input logic e, input logic [1:0] s, input int n);
    logic [3:0] r;
    r = '0;
    if (e && int'(s) < n) r[s] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_dq_a, exp_dq_b;
    logic       exp_v_a, exp_v_b;
    logic [3:0] tbl [4];
    tbl[0] = 4'b0001; tbl[1] = 4'b0010; tbl[2] = 4'b0100; tbl[3] = 4'b1000;
    checks   = 0;
    failures = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    en    = 1'b1;
    sel   = 2'd0;

    #1;
    check("reset_dec_q_a", 32'(dec_q_a), 32'h0);
    check("reset_valid_q_a", 32'(valid_q_a), 32'h0);
    check("reset_dec_q_b", 32'(dec_q_b), 32'h0);
    check("reset_comb_dec_a", 32'(dec_a), 32'h1);
    tick();
    tick();
    rst_n = 1'b1;

    // Combinational sweep, no clock edge involved
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      check("sweep_dec_a", 32'(dec_a), 32'(tbl[s]));
      check("sweep_in_range_a", 32'(in_range_a), 32'h1);
    end

    // Disabled: all decode bits low, range still reported
    en = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      check("dis_dec_a", 32'(dec_a), 32'h0);
      check("dis_in_range_a", 32'(in_range_a), 32'h1);
    end
    tick();
    check("dis_dec_q_a", 32'(dec_q_a), 32'h0);
    check("dis_valid_q_a", 32'(valid_q_a), 32'h0);

    // One-cycle latency
    en  = 1'b1;
    sel = 2'd2;
    tick();
    check("lat_dec_q_n", 32'(dec_q_a), 32'h4);
    check("lat_valid_q_n", 32'(valid_q_a), 32'h1);
    sel = 2'd1;
    #1;
    check("lat_dec_q_hold", 32'(dec_q_a), 32'h4);
    tick();
    check("lat_dec_q_n1", 32'(dec_q_a), 32'h2);

    // Asynchronous reset between edges
    sel = 2'd3;
    tick();
    check("pre_rst_dec_q", 32'(dec_q_a), 32'h8);
    check("pre_rst_valid_q", 32'(valid_q_a), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_dec_q", 32'(dec_q_a), 32'h0);
    check("async_rst_valid_q", 32'(valid_q_a), 32'h0);
    check("async_rst_comb_dec", 32'(dec_a), 32'h8);
    #1 rst_n = 1'b1;
    #1;
    check("rel_dec_q_before_edge", 32'(dec_q_a), 32'h0);
    tick();
    check("rel_dec_q", 32'(dec_q_a), 32'h8);
    check("rel_valid_q", 32'(valid_q_a), 32'h1);

    // Narrow decoder out-of-range code
    sel = 2'd3;
    #1;
    check("b_oor_dec", 32'(dec_b), 32'h0);
    check("b_oor_in_range", 32'(in_range_b), 32'h0);
    tick();
    check("b_oor_valid_q", 32'(valid_q_b), 32'h0);
    check("b_oor_dec_q", 32'(dec_q_b), 32'h0);
    sel = 2'd2;
    #1;
    check("b_sel2_dec", 32'(dec_b), 32'h4);
    check("b_sel2_in_range", 32'(in_range_b), 32'h1);
    tick();
    check("b_sel2_valid_q", 32'(valid_q_b), 32'h1);

    // Random run on both decoders
    for (int i = 0; i < 1000; i++) begin
      en  = 1'($urandom_range(0, 3) != 0);
      sel = 2'($urandom_range(0, 3));
      #1;
      check("rnd_onehot_a", 32'($countones(dec_a) <= 1), 32'h1);
      check("rnd_onehot_b", 32'($countones(dec_b) <= 1), 32'h1);
      check("rnd_dec_a", 32'(dec_a), 32'(ref_dec(en, sel, 4)));
      check("rnd_dec_b", 32'(dec_b), 32'(ref_dec(en, sel, 3)));
      exp_dq_a = ref_dec(en, sel, 4);
      exp_dq_b = ref_dec(en, sel, 3);
      exp_v_a  = en;
      exp_v_b  = en && (sel != 2'd3);
      tick();
      check("rnd_dec_q_a", 32'(dec_q_a), 32'(exp_dq_a));
      check("rnd_valid_q_a", 32'(valid_q_a), 32'(exp_v_a));
      check("rnd_dec_q_b", 32'(dec_q_b), 32'(exp_dq_b[2:0]));
      check("rnd_valid_q_b", 32'(valid_q_b), 32'(exp_v_b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
